hazard3_pmp_loader: RTL and testbench

HAZARD3_PMP_LOADER -- requirements
Module: hazard3_pmp_loader

---
 rtl/hazard3_pmp_loader_pkg.sv | 20 ++
 rtl/hazard3_pmp_loader.sv | 175 +++++++++++++++++
 tb/tb_hazard3_pmp_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard3_pmp_loader_pkg.sv
// Shared constants and helpers for the PMP table loader.
// Holds the PMP CSR base addresses and the byte-merge used for read-modify-write of pmpcfgN.
package hazard3_pmp_loader_pkg;

    localparam logic [11:0] PMPCFG0  = 12'h3A0;
    localparam logic [11:0] PMPADDR0 = 12'h3B0;

    // Replace one byte lane of a pmpcfgN word, leaving the other three regions untouched.
    function automatic logic [31:0] cfg_byte_merge(
        input logic [31:0] word,
        input logic [1:0]  sel,
        input logic [7:0]  new_byte
    );
        logic [31:0] merged;
        merged = word;
        merged[{sel, 3'b000} +: 8] = new_byte;
        return merged;
    endfunction

endpackage

// File: rtl/hazard3_pmp_loader.sv
// Walks a memory table of {pmpaddr, pmpcfg} pairs and programs the PMP through its cfg port.
// Locked regions are detected by re-reading pmpcfgN before each region and are skipped.
module hazard3_pmp_loader
    import hazard3_pmp_loader_pkg::*;
#(
    parameter int PMP_REGIONS = 4,
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [W_ADDR-1:0]      tbl_base,
    output logic                   tbl_req,
    output logic [W_ADDR-1:0]      tbl_addr,
    input  logic                   tbl_gnt,
    input  logic                   tbl_rvalid,
    input  logic [W_DATA-1:0]      tbl_rdata,
    input  logic                   tbl_err,
    output logic [11:0]            cfg_addr,
    output logic                   cfg_wen,
    output logic [W_DATA-1:0]      cfg_wdata,
    input  logic [W_DATA-1:0]      cfg_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [PMP_REGIONS-1:0] skipped
);

    localparam int W_IDX = $clog2(PMP_REGIONS) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_A = 3'd1;
    localparam logic [2:0] S_FETCH_C = 3'd2;
    localparam logic [2:0] S_RD_CFG  = 3'd3;
    localparam logic [2:0] S_WR_ADDR = 3'd4;
    localparam logic [2:0] S_WR_CFG  = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    logic [2:0]             r_state;
    logic [W_IDX-1:0]       r_idx;
    logic [W_ADDR-1:0]      r_base;
    logic [W_ADDR-1:0]      r_tbl_addr;
    logic                   r_tbl_req;
    logic                   r_pending;
    logic                   r_err;
    logic [PMP_REGIONS-1:0] r_skipped;
    logic [W_DATA-1:0]      r_addr_word;
    logic [W_DATA-1:0]      r_shadow;
    logic [7:0]             r_cfg_byte;

    logic [4:0]             w_idx5;
    logic [1:0]             w_byte_sel;
    logic [11:0]            w_cfg_csr;
    logic [11:0]            w_addr_csr;
    logic [W_IDX-1:0]       w_idx_next;
    logic [W_ADDR-1:0]      w_next_addr;
    logic                   w_last;
    logic                   w_locked;
    logic                   w_advance;
    logic [PMP_REGIONS-1:0] w_idx_mask;

    assign w_idx5      = 5'(r_idx);
    assign w_byte_sel  = w_idx5[1:0];
    assign w_cfg_csr   = PMPCFG0 + {9'd0, w_idx5[4:2]};
    assign w_addr_csr  = PMPADDR0 + {7'd0, w_idx5};
    assign w_idx_next  = r_idx + W_IDX'(1);
    assign w_next_addr = r_base + (W_ADDR'(w_idx_next) << 3);
    assign w_last      = (r_idx == W_IDX'(PMP_REGIONS - 1));
    assign w_locked    = cfg_rdata[{w_byte_sel, 3'b111}];
    assign w_idx_mask  = PMP_REGIONS'(1) << r_idx;
    assign w_advance   = (r_state == S_WR_CFG) || ((r_state == S_RD_CFG) && w_locked);

    assign tbl_req  = r_tbl_req;
    assign tbl_addr = r_tbl_addr;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FINISH);
    assign err      = r_err;
    assign skipped  = r_skipped;

    always_comb begin
        cfg_addr  = '0;
        cfg_wen   = 1'b0;
        cfg_wdata = '0;
        case (r_state)
            S_RD_CFG: cfg_addr = w_cfg_csr;
            S_WR_ADDR: begin
                cfg_addr  = w_addr_csr;
                cfg_wen   = 1'b1;
                cfg_wdata = r_addr_word;
            end
            S_WR_CFG: begin
                cfg_addr  = w_cfg_csr;
                cfg_wen   = 1'b1;
                cfg_wdata = cfg_byte_merge(r_shadow, w_byte_sel, r_cfg_byte);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_base      <= '0;
            r_tbl_addr  <= '0;
            r_tbl_req   <= 1'b0;
            r_pending   <= 1'b0;
            r_err       <= 1'b0;
            r_skipped   <= '0;
            r_addr_word <= '0;
            r_shadow    <= '0;
            r_cfg_byte  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH_A;
                        r_idx      <= '0;
                        r_base     <= tbl_base;
                        r_tbl_req  <= 1'b1;
                        r_tbl_addr <= tbl_base;
                        r_err      <= 1'b0;
                        r_skipped  <= '0;
                    end
                end
                S_FETCH_A, S_FETCH_C: begin
                    if (r_tbl_req && tbl_gnt) begin
                        r_tbl_req <= 1'b0;
                        r_pending <= 1'b1;
                    end
                    // Responses only count once our grant has been taken.
                    if (r_pending && tbl_rvalid) begin
                        r_pending <= 1'b0;
                        if (tbl_err) begin
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (r_state == S_FETCH_A) begin
                            r_addr_word <= tbl_rdata;
                            r_state     <= S_FETCH_C;
                            r_tbl_req   <= 1'b1;
                            r_tbl_addr  <= r_tbl_addr + W_ADDR'(4);
                        end else begin
                            r_cfg_byte <= tbl_rdata[7:0];
                            r_state    <= S_RD_CFG;
                        end
                    end
                end
                S_RD_CFG: begin
                    r_shadow <= cfg_rdata;
                    if (w_locked) begin
                        r_skipped <= r_skipped | w_idx_mask;
                    end else begin
                        r_state <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: r_state <= S_WR_CFG;
                S_FINISH:  r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase

            if (w_advance) begin
                if (w_last) begin
                    r_state <= S_FINISH;
                end else begin
                    r_idx      <= w_idx_next;
                    r_state    <= S_FETCH_A;
                    r_tbl_req  <= 1'b1;
                    r_tbl_addr <= w_next_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard3_pmp_loader.sv
// Directed bench for hazard3_pmp_loader: table memory responder plus a 4-region PMP cfg-port model.
module tb_hazard3_pmp_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] tbl_base = '0;
    logic        tbl_req;
    logic [31:0] tbl_addr;
    logic        tbl_gnt = 1'b0;
    logic        tbl_rvalid = 1'b0;
    logic [31:0] tbl_rdata = '0;
    logic        tbl_err = 1'b0;
    logic [11:0] cfg_addr;
    logic        cfg_wen;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  skipped;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tbl_mem [0:1023];
    int          stall_cycles = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int          gnt_wait = 0;
    logic        rsp_pending = 1'b0;
    logic [31:0] rsp_addr = '0;

    logic [31:0] pmpcfg0;
    logic [31:0] pmpaddr [0:3];
    logic        do_preset = 1'b0;
    logic [31:0] preset_cfg0 = '0;

    hazard3_pmp_loader #(
        .PMP_REGIONS(4),
        .W_ADDR     (32),
        .W_DATA     (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tbl_base  (tbl_base),
        .tbl_req   (tbl_req),
        .tbl_addr  (tbl_addr),
        .tbl_gnt   (tbl_gnt),
        .tbl_rvalid(tbl_rvalid),
        .tbl_rdata (tbl_rdata),
        .tbl_err   (tbl_err),
        .cfg_addr  (cfg_addr),
        .cfg_wen   (cfg_wen),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .skipped   (skipped)
    );

    always #5 clk = ~clk;

    // Table responder: grant after stall_cycles of waiting, data exactly one cycle after grant.
    always @(negedge clk) begin
        tbl_gnt    = 1'b0;
        tbl_rvalid = 1'b0;
        tbl_err    = 1'b0;
        tbl_rdata  = '0;
        if (rsp_pending) begin
            tbl_rvalid  = 1'b1;
            tbl_rdata   = tbl_mem[rsp_addr[11:2]];
            tbl_err     = err_en && (rsp_addr == err_addr);
            rsp_pending = 1'b0;
        end else if (tbl_req) begin
            if (gnt_wait < stall_cycles) begin
                gnt_wait++;
            end else begin
                tbl_gnt     = 1'b1;
                gnt_wait    = 0;
                rsp_pending = 1'b1;
                rsp_addr    = tbl_addr;
            end
        end
    end

    // PMP cfg-port responder: pmpcfg0 and pmpaddr0..3.
    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr == 12'h3A0)
            cfg_rdata = pmpcfg0;
        else if (cfg_addr >= 12'h3B0 && cfg_addr <= 12'h3B3)
            cfg_rdata = pmpaddr[cfg_addr[1:0]];
    end

    always @(posedge clk) begin
        if (do_preset) begin
            pmpcfg0 <= preset_cfg0;
            for (int i = 0; i < 4; i++) pmpaddr[i] <= 32'hDEAD_0000 + 32'(i);
        end else if (cfg_wen) begin
            if (cfg_addr == 12'h3A0)
                pmpcfg0 <= cfg_wdata;
            else if (cfg_addr >= 12'h3B0 && cfg_addr <= 12'h3B3)
                pmpaddr[cfg_addr[1:0]] <= cfg_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input logic [31:0] base, input int i, input logic [31:0] a, input logic [31:0] c);
        logic [31:0] wa;
        wa = base + 32'(8 * i);
        tbl_mem[wa[11:2]] = a;
        wa = wa + 32'd4;
        tbl_mem[wa[11:2]] = c;
    endtask

    task automatic preset(input logic [31:0] cfg);
        @(negedge clk);
        preset_cfg0 = cfg;
        do_preset   = 1'b1;
        @(negedge clk);
        do_preset   = 1'b0;
    endtask

    // Run one load; optionally check request stability, re-pulse start, or reset mid-load.
    task automatic run_load(input string name, input logic [31:0] base, input int stall_chk,
                            input int restart_at, input int rst_at, output int cycles);
        logic rst_hit;
        rst_hit = 1'b0;
        @(negedge clk);
        tbl_base = base;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        check({name, "_busy_on"}, busy, 1);
        check({name, "_err_clr"}, err, 0);
        check({name, "_skip_clr"}, skipped, 0);
        while (!done && cycles < 500 && !rst_hit) begin
            if (cycles < stall_chk) begin
                check({name, "_stall_req"}, tbl_req, 1);
                check({name, "_stall_addr"}, tbl_addr, base);
            end
            if (cycles == restart_at) begin
                tbl_base = 32'h0000_0F00;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cycles == rst_at) begin
                check({name, "_wr_wen"}, cfg_wen, 1);
                check({name, "_wr_addr"}, cfg_addr, 12'h3B1);
                check({name, "_wr_data"}, cfg_wdata, 32'h0000_0222);
                rst_n = 1'b0;
                @(negedge clk);
                check({name, "_rst_busy"}, busy, 0);
                check({name, "_rst_wen"}, cfg_wen, 0);
                check({name, "_rst_req"}, tbl_req, 0);
                rst_n   = 1'b1;
                rst_hit = 1'b1;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        start = 1'b0;
        if (!rst_hit) begin
            if (cycles >= 500) begin
                check({name, "_done_timeout"}, 0, 1);
            end else begin
                @(negedge clk);
                check({name, "_done_pulse"}, done, 0);
                check({name, "_busy_off"}, busy, 0);
            end
        end
        $display("load %s base=0x%08h cycles=%0d err=%0b skipped=%04b pmpcfg0=0x%08h",
                 name, base, cycles, err, skipped, pmpcfg0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) tbl_mem[i] = 32'hBAD0_0000 + 32'(i);
        set_entry(32'h40, 0, 32'h0000_0FFF, 32'h0000_001F);
        set_entry(32'h40, 1, 32'h2000_0000, 32'h0000_0019);
        set_entry(32'h40, 2, 32'h0000_0000, 32'h0000_0000);
        set_entry(32'h40, 3, 32'h0000_0000, 32'h0000_0000);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] b;
            b = (i == 0) ? 32'h80 : 32'hC0;
            set_entry(b, 0, 32'h0000_0111, 32'hABCD_EF1F);
            set_entry(b, 1, 32'h0000_0222, 32'hABCD_EF1B);
            set_entry(b, 2, 32'h0000_0333, 32'hABCD_EF0F);
            set_entry(b, 3, 32'h0000_0444, 32'hABCD_EF07);
        end

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_skipped", skipped, 0);
        check("rst_tbl_req", tbl_req, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_cfg_wen", cfg_wen, 0);
        check("rst_cfg_addr", cfg_addr, 0);
        check("rst_cfg_wdata", cfg_wdata, 0);
        rst_n = 1'b1;

        // Basic four-region load from a zero-wait table.
        preset(32'h0);
        run_load("basic", 32'h40, 0, -1, -1, cyc);
        check("basic_cycles", cyc, 28);
        check("basic_err", err, 0);
        check("basic_addr0", pmpaddr[0], 32'h0000_0FFF);
        check("basic_addr1", pmpaddr[1], 32'h2000_0000);
        check("basic_addr2", pmpaddr[2], 32'h0);
        check("basic_addr3", pmpaddr[3], 32'h0);
        check("basic_cfg0", pmpcfg0, 32'h0000_191F);

        // Region 1 pre-locked.
        preset(32'h0000_8000);
        run_load("locked", 32'h80, 0, -1, -1, cyc);
        check("locked_cycles", cyc, 26);
        check("locked_skipped", skipped, 4'b0010);
        check("locked_addr0", pmpaddr[0], 32'h0000_0111);
        check("locked_addr1", pmpaddr[1], 32'hDEAD_0001);
        check("locked_addr2", pmpaddr[2], 32'h0000_0333);
        check("locked_addr3", pmpaddr[3], 32'h0000_0444);
        check("locked_cfg0", pmpcfg0, 32'h070F_801F);

        // Bus error on region 2's cfg word.
        preset(32'h0);
        err_en   = 1'b1;
        err_addr = 32'hC0 + 32'd20;
        run_load("tblerr", 32'hC0, 0, -1, -1, cyc);
        err_en   = 1'b0;
        check("tblerr_cycles", cyc, 18);
        check("tblerr_err", err, 1);
        check("tblerr_addr0", pmpaddr[0], 32'h0000_0111);
        check("tblerr_addr1", pmpaddr[1], 32'h0000_0222);
        check("tblerr_addr2", pmpaddr[2], 32'hDEAD_0002);
        check("tblerr_cfg0", pmpcfg0, 32'h0000_1B1F);

        // Every grant stalled 5 cycles; a second start while busy must be ignored.
        preset(32'h0);
        stall_cycles = 5;
        run_load("stall", 32'h40, 6, 10, -1, cyc);
        stall_cycles = 0;
        check("stall_cycles", cyc, 68);
        check("stall_err_clr", err, 0);
        check("stall_addr0", pmpaddr[0], 32'h0000_0FFF);
        check("stall_cfg0", pmpcfg0, 32'h0000_191F);
        repeat (3) @(negedge clk);
        check("stall_idle", busy, 0);

        // Reset during region 1's pmpaddr write.
        preset(32'h0);
        run_load("midrst", 32'h80, 0, -1, 12, cyc);
        repeat (3) @(negedge clk);
        check("midrst_idle", busy, 0);
        check("midrst_addr0", pmpaddr[0], 32'h0000_0111);
        check("midrst_addr1", pmpaddr[1], 32'hDEAD_0001);
        check("midrst_cfg0", pmpcfg0, 32'h0000_001F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
